// File: rtl/arm_mc_mainfsm.sv
// Main control FSM for the multicycle ARM core: variable-latency memory handshake,
// wait-state watchdog trapping to a sticky FAULT state, and a retired-instruction counter.
module arm_mc_mainfsm #(
  parameter int MAX_WAIT = 16,
  parameter int WAIT_W   = 5,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       Op,
  input  logic [5:0]       Funct,
  input  logic             MemReady,
  output logic             MemReq,
  output logic             IRWrite,
  output logic             AdrSrc,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ResultSrc,
  output logic             ALUOp,
  output logic             NextPC,
  output logic             RegW,
  output logic             MemW,
  output logic             Branch,
  output logic             MemErr,
  output logic [CNT_W-1:0] InstrCount,
  output logic [3:0]       dbg_state_o
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECUTER, EXECUTEI, ALUWB, BRANCH, FAULT
  } state_t;

  localparam logic [WAIT_W-1:0] WAIT_LAST = (MAX_WAIT == 0) ? '0 : WAIT_W'(MAX_WAIT - 1);

  state_t             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               waiting, timeout, retire;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      wait_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    waiting = ((state_q == FETCH) || (state_q == MEMREAD) || (state_q == MEMWRITE)) && !MemReady;
    timeout = (MAX_WAIT != 0) && waiting && (wait_q == WAIT_LAST);
    case (state_q)
      FETCH:    if (MemReady) state_d = DECODE;
      DECODE: begin
        case (Op)
          2'b01:   state_d = MEMADR;
          2'b10:   state_d = BRANCH;
          2'b00:   state_d = Funct[5] ? EXECUTEI : EXECUTER;
          default: begin
            state_d = FETCH;
            retire  = 1'b1;
          end
        endcase
      end
      MEMADR:   state_d = Funct[0] ? MEMREAD : MEMWRITE;
      MEMREAD:  if (MemReady) state_d = MEMWB;
      MEMWRITE: begin
        if (MemReady) begin
          state_d = FETCH;
          retire  = 1'b1;
        end
      end
      EXECUTER, EXECUTEI: state_d = ALUWB;
      MEMWB, ALUWB, BRANCH: begin
        state_d = FETCH;
        retire  = 1'b1;
      end
      FAULT:    state_d = FAULT;
      default:  state_d = FETCH;
    endcase
    // A ready memory wins over the watchdog in the same cycle (waiting is then low).
    if (timeout) state_d = FAULT;
    if (state_d != state_q) wait_d = '0;
    else if (waiting)       wait_d = wait_q + WAIT_W'(1);
    else                    wait_d = wait_q;
    count_d = retire ? count_q + CNT_W'(1) : count_q;
  end

  always_comb begin
    MemReq    = 1'b0;
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    ALUOp     = 1'b0;
    NextPC    = 1'b0;
    RegW      = 1'b0;
    MemW      = 1'b0;
    Branch    = 1'b0;
    MemErr    = 1'b0;
    case (state_q)
      FETCH: begin
        MemReq    = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = MemReady;
        NextPC    = MemReady;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      MEMADR:   ALUSrcB = 2'b01;
      MEMREAD: begin
        MemReq = 1'b1;
        AdrSrc = 1'b1;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegW      = 1'b1;
      end
      MEMWRITE: begin
        MemReq = 1'b1;
        MemW   = 1'b1;
        AdrSrc = 1'b1;
      end
      EXECUTER: ALUOp = 1'b1;
      EXECUTEI: begin
        ALUSrcB = 2'b01;
        ALUOp   = 1'b1;
      end
      ALUWB:    RegW = 1'b1;
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        Branch    = 1'b1;
      end
      FAULT:    MemErr = 1'b1;
      default:  ;
    endcase
  end

  assign InstrCount  = count_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_arm_mc_mainfsm.sv
// Bench for arm_mc_mainfsm: each instruction is expanded into its expected per-cycle
// control words, then replayed against the DUT one cycle at a time.
module tb_arm_mc_mainfsm;
  localparam int MW = 4;
  localparam int WW = 3;
  localparam int CW = 4;

  localparam int ST_FETCH = 0, ST_DECODE = 1, ST_MEMADR = 2, ST_MEMREAD = 3, ST_MEMWB = 4,
                 ST_MEMWRITE = 5, ST_EXECR = 6, ST_EXECI = 7, ST_ALUWB = 8, ST_BRANCH = 9,
                 ST_FAULT = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    Op;
  logic [5:0]    Funct;
  logic          MemReady;
  logic          MemReq, IRWrite, AdrSrc, ALUSrcA, ALUOp, NextPC, RegW, MemW, Branch, MemErr;
  logic [1:0]    ALUSrcB, ResultSrc;
  logic [CW-1:0] InstrCount;
  logic [3:0]    dbg_state;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;
  // step word: {op[1:0], funct[5:0], retire, ready, ctrl[13:0]}
  logic [23:0] exp_q[$];

  arm_mc_mainfsm #(.MAX_WAIT(MW), .WAIT_W(WW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .MemReady(MemReady),
    .MemReq(MemReq), .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ALUOp(ALUOp), .NextPC(NextPC),
    .RegW(RegW), .MemW(MemW), .Branch(Branch), .MemErr(MemErr),
    .InstrCount(InstrCount), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  // {MemReq, IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp, NextPC, RegW, MemW, Branch, MemErr}
  function automatic logic [13:0] ctrl_of(input int st, input logic rdy);
    case (st)
      ST_FETCH:    return {1'b1, rdy, 1'b0, 1'b1, 2'b10, 2'b10, 1'b0, rdy, 4'b0000};
      ST_DECODE:   return {1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b10, 1'b0, 1'b0, 4'b0000};
      ST_MEMADR:   return {1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 4'b0000};
      ST_MEMREAD:  return {1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 4'b0000};
      ST_MEMWB:    return {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 1'b0, 1'b0, 4'b1000};
      ST_MEMWRITE: return {1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 4'b0100};
      ST_EXECR:    return {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 4'b0000};
      ST_EXECI:    return {1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 4'b0000};
      ST_ALUWB:    return {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 4'b1000};
      ST_BRANCH:   return {1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 1'b0, 1'b0, 4'b0010};
      default:     return 14'b00_0000_0000_0001;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int st, input logic rdy, input logic ret,
                      input logic [1:0] op, input logic [5:0] fn);
    exp_q.push_back({op, fn, ret, rdy, ctrl_of(st, rdy)});
  endtask

  // Steps whose outputs must not depend on MemReady get a random MemReady.
  task automatic push_any(input int st, input logic ret, input logic [1:0] op, input logic [5:0] fn);
    push(st, 1'($urandom_range(0, 1)), ret, op, fn);
  endtask

  task automatic wait_phase(input int st, input int w, input logic [1:0] op, input logic [5:0] fn,
                            output bit faulted);
    int n;
    faulted = (w >= MW);
    n = faulted ? MW : w;
    for (int i = 0; i < n; i++) push(st, 1'b0, 1'b0, op, fn);
    if (faulted) begin
      for (int i = 0; i < 3; i++) push(ST_FAULT, 1'b1, 1'b0, op, fn);
      push(ST_FAULT, 1'b0, 1'b0, op, fn);
    end
  endtask

  // Expected cycle sequence of one instruction; wf/wm = MemReady-low cycles in fetch/data access.
  task automatic expand(input logic [1:0] op, input logic [5:0] fn, input int wf, input int wm);
    bit flt;
    wait_phase(ST_FETCH, wf, op, fn, flt);
    if (flt) return;
    push(ST_FETCH, 1'b1, 1'b0, op, fn);
    if (op == 2'b11) begin
      push_any(ST_DECODE, 1'b1, op, fn);
      return;
    end
    push_any(ST_DECODE, 1'b0, op, fn);
    case (op)
      2'b10: push_any(ST_BRANCH, 1'b1, op, fn);
      2'b00: begin
        push_any(fn[5] ? ST_EXECI : ST_EXECR, 1'b0, op, fn);
        push_any(ST_ALUWB, 1'b1, op, fn);
      end
      default: begin
        push_any(ST_MEMADR, 1'b0, op, fn);
        if (fn[0]) begin
          wait_phase(ST_MEMREAD, wm, op, fn, flt);
          if (flt) return;
          push(ST_MEMREAD, 1'b1, 1'b0, op, fn);
          push_any(ST_MEMWB, 1'b1, op, fn);
        end else begin
          wait_phase(ST_MEMWRITE, wm, op, fn, flt);
          if (flt) return;
          push(ST_MEMWRITE, 1'b1, 1'b1, op, fn);
        end
      end
    endcase
  endtask

  task automatic run_steps(input string tag);
    logic [23:0] s;
    while (exp_q.size() > 0) begin
      s = exp_q.pop_front();
      @(negedge clk);
      Op       = s[23:22];
      Funct    = s[21:16];
      MemReady = s[14];
      #1;
      chk({tag, ".ctrl"}, {18'd0, MemReq, IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
                           ALUOp, NextPC, RegW, MemW, Branch, MemErr}, {18'd0, s[13:0]});
      chk({tag, ".count"}, 32'(InstrCount), 32'(exp_cnt));
      @(posedge clk);
      if (s[15]) exp_cnt = (exp_cnt + 1) % (1 << CW);
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset    = 1'b1;
    MemReady = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    exp_cnt = 0;
  endtask

  initial begin
    reset = 1'b1; Op = 2'b00; Funct = 6'd0; MemReady = 1'b0;
    reset_dut();

    expand(2'b00, 6'b000000, 0, 0);
    run_steps("add");
    #1 chk("add.retired", 32'(InstrCount), 32'd1);

    expand(2'b01, 6'b011001, 0, 3);
    run_steps("ldr_wait3");
    expand(2'b01, 6'b010000, 0, 2);
    run_steps("str_wait2");
    expand(2'b11, 6'b000000, 0, 0);
    run_steps("nop");
    #1 chk("nop.retired", 32'(InstrCount), 32'd4);

    expand(2'b10, 6'b000000, MW - 1, 0);
    expand(2'b01, 6'b000001, 0, MW - 1);
    expand(2'b01, 6'b000000, MW - 1, MW - 1);
    run_steps("ready_on_last_wait");

    reset_dut();
    for (int i = 0; i < 17; i++) expand(2'b10, 6'($urandom_range(0, 63)), $urandom_range(0, 1), 0);
    run_steps("branch_wrap");
    #1 chk("branch_wrap.count", 32'(InstrCount), 32'd1);

    for (int i = 0; i < 60; i++)
      expand(2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)),
             $urandom_range(0, MW - 1), $urandom_range(0, MW - 1));
    run_steps("random");

    reset_dut();
    expand(2'b00, 6'b000000, MW, 0);
    run_steps("fault_fetch");
    reset_dut();
    expand(2'b10, 6'b000000, 0, 0);
    run_steps("after_fault");
    #1 chk("after_fault.memerr", 32'(MemErr), 32'd0);

    expand(2'b01, 6'b000001, 1, MW + 1);
    run_steps("fault_memread");
    reset_dut();
    expand(2'b01, 6'b000000, 0, MW);
    run_steps("fault_memwrite");
    reset_dut();

    expand(2'b11, 6'b000000, 0, 0);
    push(ST_FETCH, 1'b1, 1'b0, 2'b01, 6'b000000);
    push_any(ST_DECODE, 1'b0, 2'b01, 6'b000000);
    push_any(ST_MEMADR, 1'b0, 2'b01, 6'b000000);
    push(ST_MEMWRITE, 1'b0, 1'b0, 2'b01, 6'b000000);
    push(ST_MEMWRITE, 1'b0, 1'b0, 2'b01, 6'b000000);
    run_steps("pre_midreset");
    @(negedge clk);
    reset = 1'b1;
    MemReady = 1'b0;
    #1 chk("midreset.memw_held", 32'(MemW), 32'd1);
    @(posedge clk);
    #1 reset = 1'b0;
    exp_cnt = 0;
    chk("midreset.count", 32'(InstrCount), 32'd0);
    chk("midreset.memw", 32'(MemW), 32'd0);
    expand(2'b11, 6'b000000, 0, 0);
    expand(2'b01, 6'b000001, 0, 0);
    run_steps("post_midreset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
